// File: rtl/rv_pkg.sv
// Shared front-end definitions: datapath widths, default reset vector and fetch FSM encoding.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous instruction buffer: registered head, flush clears contents, occupancy count out.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             do_push_c, do_pop_c;

  // A push into a full buffer is only legal when the head leaves on the same edge.
  assign do_pop_c  = pop && valid_q;
  assign do_push_c = push && ((count_q != CNT_W'(DEPTH)) || do_pop_c);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign valid = valid_q;
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps one request outstanding against imem,
// buffers returned words and hands {pc, instr} to decode; redirects flush and squash.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned       ADDR_W     = XLEN,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [ILEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ILEN-1:0]   instr_data,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int unsigned       ENTRY_W   = ADDR_W + ILEN;
  localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] START_PC  = RESET_PC & WORD_MASK;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
  logic              req_q, req_d;
  logic              armed_q, armed_d;

  logic              accept_c, push_c, pop_c, credit_c;
  logic [CNT_W-1:0]  fifo_count, count_after_c;
  logic              fifo_valid;
  logic [ENTRY_W-1:0] fifo_head;

  assign accept_c = req_q && imem_ready;
  assign push_c   = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign pop_c    = fifo_valid && instr_ready;

  // Credit looks at occupancy after this edge so a new request never overruns the buffer.
  assign count_after_c = redirect_valid ? '0
                       : fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
  assign credit_c      = (count_after_c < DEPTH_CNT);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    req_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (credit_c) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ready) begin
          state_d    = ST_WAIT;
          issue_pc_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) state_d = credit_c ? ST_REQ : ST_IDLE;
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides everything; an in-flight response must be squashed in DROP.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & WORD_MASK;
      unique case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ:  state_d = imem_ready ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = imem_rvalid ? ST_REQ : ST_DROP;
        ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end

    req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= START_PC;
      issue_pc_q <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      req_q      <= req_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .flush     (redirect_valid),
    .push      (push_c),
    .push_data ({issue_pc_q, imem_rdata}),
    .pop       (pop_c),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign imem_req               = req_q;
  assign imem_addr              = fetch_pc_q;
  assign instr_valid            = fifo_valid;
  assign {instr_pc, instr_data} = fifo_head;

  // A response still in flight across reset may legally land before the first new accept.
  assign armed_d = armed_q | accept_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed_q <= 1'b0;
    else      armed_q <= armed_d;
  end

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst)
    (imem_rvalid && armed_q) |-> (state_q == ST_WAIT || state_q == ST_DROP)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table plus hand sequences for stall, drop and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;

  logic        imem_req, imem_req_b;
  logic [31:0] imem_addr, imem_addr_b;
  logic        instr_valid, instr_valid_b;
  logic [31:0] instr_data, instr_data_b;
  logic [31:0] instr_pc, instr_pc_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  // Second instance shadows the first with a reset vector just below the wrap point.
  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid_b), .instr_ready(instr_ready),
    .instr_data(instr_data_b), .instr_pc(instr_pc_b)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: fixed latency after accept, optional injected stray response.
  int          mem_lat = 1;
  int          inj_req = 0;
  int          inj_done = 0;
  bit          inflight = 0;
  int          left = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] acc_log[$];

  always @(posedge clk) begin
    bit          acc_v;
    logic [31:0] a_v;
    acc_v = rst && imem_req && imem_ready;
    a_v   = imem_addr;
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (!rst) begin
      inflight = 0;
    end else begin
      if (inj_req != inj_done) begin
        inj_done++;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
      end
      if (inflight) begin
        left--;
        if (left == 0) begin
          inflight    = 0;
          imem_rvalid = 1'b1;
          imem_rdata  = mdata(pend_addr);
        end
      end
      if (acc_v) begin
        acc_log.push_back(a_v);
        if (mem_lat <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mdata(a_v);
        end else begin
          inflight  = 1;
          left      = mem_lat - 1;
          pend_addr = a_v;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    imem_ready     = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_lat        = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    acc_log.delete();
  endtask

  typedef struct {
    bit          rst_first;
    bit          rdy;
    bit          irdy;
    bit          redir;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          chk_b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit rf, bit rdy, bit irdy, bit redir, logic [31:0] rpc,
                             bit e_req, logic [31:0] e_addr, bit e_valid, logic [31:0] e_pc,
                             bit chk_b);
    vec_t r;
    r.rst_first = rf;   r.rdy = rdy;       r.irdy = irdy;       r.redir = redir;
    r.rpc = rpc;        r.e_req = e_req;   r.e_addr = e_addr;   r.e_valid = e_valid;
    r.e_pc = e_pc;      r.chk_b = chk_b;
    return r;
  endfunction

  initial begin
    // Streaming from reset, decode always ready; instance B checks the address wrap.
    vecs.push_back(v(1, 1, 1, 0, 0, 0, 32'h0, 0, 0, 1));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'h0, 0, 0, 1));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h4, 0, 0, 1));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'h4, 1, 32'h0, 1));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h8, 0, 0, 1));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'h8, 1, 32'h4, 1));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'hC, 0, 0, 1));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'hC, 1, 32'h8, 1));
    // Decode stalled: two words fill the buffer, fetch idles, then drains and resumes at 8.
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 32'h4, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 1, 32'h4, 1, 32'h0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 32'h8, 1, 32'h0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 32'h8, 1, 32'h0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h8, 1, 32'h0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'h8, 1, 32'h4, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'hC, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'hC, 1, 32'h8, 0));
    // Redirect to an unaligned target while the word from 4 is returning.
    vecs.push_back(v(1, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'h0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h4, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'h4, 1, 32'h0, 0));
    vecs.push_back(v(0, 1, 1, 1, 32'h103, 0, 32'h8, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'h100, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h104, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 1, 32'h104, 1, 32'h100, 0));

    // Power-on reset values.
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_addr_b", imem_addr_b, 32'hFFFF_FFF8);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) do_reset();
      imem_ready     = vecs[i].rdy;
      instr_ready    = vecs[i].irdy;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      chk($sformatf("v%0d_req", i), imem_req, vecs[i].e_req);
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), instr_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_data", i), instr_data, mdata(vecs[i].e_pc));
      end
      if (vecs[i].chk_b) begin
        chk($sformatf("v%0d_req_b", i), imem_req_b, vecs[i].e_req);
        chk($sformatf("v%0d_addr_b", i), imem_addr_b, vecs[i].e_addr - 32'h8);
        chk($sformatf("v%0d_valid_b", i), instr_valid_b, vecs[i].e_valid);
        if (vecs[i].e_valid) begin
          chk($sformatf("v%0d_pc_b", i), instr_pc_b, vecs[i].e_pc - 32'h8);
          chk($sformatf("v%0d_data_b", i), instr_data_b, mdata(vecs[i].e_pc));
        end
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    // Memory stall for 5 cycles, redirect arrives on the last stalled cycle.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_req", k), imem_req, 1);
      chk($sformatf("stall%0d_addr", k), imem_addr, 32'h0);
      if (k == 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000_0042;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    chk("stall_redir_req", imem_req, 1);
    chk("stall_redir_addr", imem_addr, 32'h2000_0040);
    imem_ready = 1'b1;
    @(negedge clk);
    chk("stall_next_req", imem_req, 0);
    chk("stall_next_addr", imem_addr, 32'h2000_0044);
    @(negedge clk);
    chk("stall_valid", instr_valid, 1);
    chk("stall_pc", instr_pc, 32'h2000_0040);
    chk("stall_data", instr_data, mdata(32'h2000_0040));
    chk("stall_acc_cnt", 32'(acc_log.size()), 1);
    if (acc_log.size() > 0) chk("stall_acc_addr", acc_log[0], 32'h2000_0040);

    // Redirect while waiting on a slow response: response squashed, refetch from target.
    do_reset();
    mem_lat     = 3;
    imem_ready  = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("drop_c1_req", imem_req, 1);
    @(negedge clk);
    chk("drop_c2_req", imem_req, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drop_c3_req", imem_req, 0);
    chk("drop_c3_addr", imem_addr, 32'h300);
    @(negedge clk);
    chk("drop_c4_req", imem_req, 0);
    chk("drop_c4_valid", instr_valid, 0);
    @(negedge clk);
    chk("drop_c5_req", imem_req, 1);
    chk("drop_c5_addr", imem_addr, 32'h300);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("drop_c%0d_valid", 6 + k), instr_valid, 0);
    end
    @(negedge clk);
    chk("drop_c9_valid", instr_valid, 1);
    chk("drop_c9_pc", instr_pc, 32'h300);
    chk("drop_c9_data", instr_data, mdata(32'h300));

    // Reset while a response is outstanding; a stray response after release is ignored.
    do_reset();
    mem_lat     = 3;
    imem_ready  = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wait_req", imem_req, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_data", instr_data, 32'h0);
    chk("mid_rst_pc", instr_pc, 32'h0);
    chk("mid_rst_addr_b", imem_addr_b, 32'hFFFF_FFF8);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_hold_req", imem_req, 0);
    rst     = 1'b1;
    mem_lat = 1;
    acc_log.delete();
    inj_req++;
    @(negedge clk);
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("post_rst_c2_valid", instr_valid, 0);
    @(negedge clk);
    chk("post_rst_valid", instr_valid, 1);
    chk("post_rst_pc", instr_pc, 32'h0);
    chk("post_rst_data", instr_data, mdata(32'h0));
    chk("post_rst_acc_cnt", 32'(acc_log.size()), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
